// File: rtl/led_blink_ctrl.sv
// LED blinker fed by port 1 of the GPMC dual-port RAM: one scan per tick loads CTRL and
// half-period words into staging, commits them atomically, then writes a STATUS word back.
module led_blink_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_LEDS    = 4,
  parameter int PRESCALE    = 12000,
  parameter int STATUS_ADDR = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  cs,
  output logic                  we,
  output logic                  oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  logic [PW-1:0]         presc_r;
  logic                  tick_r;
  state_t                state_r, state_nxt_s;
  logic [KW-1:0]         idx_r, idx_nxt_s;
  logic [NUM_LEDS-1:0]   stg_en_r, stg_mode_r;
  logic [NUM_LEDS-1:0]   shd_en_r, shd_mode_r, shd_en_nxt_s, shd_mode_nxt_s;
  logic [DATA_WIDTH-1:0] stg_half_r [NUM_LEDS];
  logic [DATA_WIDTH-1:0] shd_half_r [NUM_LEDS];
  logic [DATA_WIDTH-1:0] shd_half_nxt_s [NUM_LEDS];
  logic [DATA_WIDTH-1:0] cnt_r [NUM_LEDS];
  logic [DATA_WIDTH-1:0] cnt_nxt_s [NUM_LEDS];
  logic [NUM_LEDS-1:0]   led_r, led_nxt_s;
  logic [7:0]            scan_cnt_r;
  logic                  cs_r, we_r, oe_r, cs_nxt_s, we_nxt_s, oe_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic [DATA_WIDTH-1:0] dout_r, dout_nxt_s;

  function automatic logic [DATA_WIDTH-1:0] status_word(input logic [7:0] sc,
                                                        input logic [NUM_LEDS-1:0] l);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[15:8] = sc;
    w[NUM_LEDS-1:0] = l;
    return w;
  endfunction

  // Prescaler; tick_r is high in the cycle the count has just wrapped to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else if (presc_r == PW'(PRESCALE - 1)) begin
      presc_r <= '0;
      tick_r  <= 1'b1;
    end else begin
      presc_r <= presc_r + PW'(1);
      tick_r  <= 1'b0;
    end
  end

  // Scan sequencing and atomic shadow commit in the WR cycle.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    shd_en_nxt_s   = (state_r == ST_WR) ? stg_en_r : shd_en_r;
    shd_mode_nxt_s = (state_r == ST_WR) ? stg_mode_r : shd_mode_r;
    for (int i = 0; i < NUM_LEDS; i++) begin
      shd_half_nxt_s[i] = (state_r == ST_WR) ? stg_half_r[i] : shd_half_r[i];
    end
    case (state_r)
      ST_IDLE: begin
        if (tick_r) begin
          state_nxt_s = ST_REQ;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ:  state_nxt_s = ST_CAP;
      ST_CAP: begin
        if (idx_r < KW'(NUM_LEDS)) begin
          state_nxt_s = ST_REQ;
          idx_nxt_s   = idx_r + KW'(1);
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_WR:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-LED rules evaluated against the shadow values that hold after this edge,
  // so a commit is visible on the LEDs in the cycle right after WR.
  always_comb begin
    led_nxt_s = led_r;
    for (int i = 0; i < NUM_LEDS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (!shd_en_nxt_s[i]) begin
        led_nxt_s[i] = 1'b0;
        cnt_nxt_s[i] = '0;
      end else if (!shd_mode_nxt_s[i]) begin
        led_nxt_s[i] = 1'b1;
        cnt_nxt_s[i] = '0;
      end else if (shd_half_nxt_s[i] == '0) begin
        led_nxt_s[i] = 1'b0;
        cnt_nxt_s[i] = '0;
      end else if (tick_r) begin
        if (cnt_r[i] >= shd_half_nxt_s[i] - DATA_WIDTH'(1)) begin
          led_nxt_s[i] = ~led_r[i];
          cnt_nxt_s[i] = '0;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + DATA_WIDTH'(1);
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // RAM port decode from the next state so the port pins come straight from flops.
  always_comb begin
    cs_nxt_s   = 1'b0;
    oe_nxt_s   = 1'b0;
    we_nxt_s   = 1'b0;
    addr_nxt_s = '0;
    dout_nxt_s = '0;
    case (state_nxt_s)
      ST_REQ: begin
        cs_nxt_s   = 1'b1;
        oe_nxt_s   = 1'b1;
        addr_nxt_s = ADDR_WIDTH'(idx_nxt_s);
      end
      ST_WR: begin
        cs_nxt_s   = 1'b1;
        we_nxt_s   = 1'b1;
        addr_nxt_s = ADDR_WIDTH'(STATUS_ADDR);
        dout_nxt_s = status_word(scan_cnt_r, led_nxt_s);
      end
      default: begin
        cs_nxt_s   = 1'b0;
        oe_nxt_s   = 1'b0;
      end
    endcase
  end

  // Scan state, staging capture, shadows, scan counter and port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      stg_en_r   <= '0;
      stg_mode_r <= '0;
      shd_en_r   <= '0;
      shd_mode_r <= '0;
      scan_cnt_r <= '0;
      cs_r       <= 1'b0;
      oe_r       <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      dout_r     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        stg_half_r[i] <= '0;
        shd_half_r[i] <= '0;
      end
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      shd_en_r   <= shd_en_nxt_s;
      shd_mode_r <= shd_mode_nxt_s;
      cs_r       <= cs_nxt_s;
      oe_r       <= oe_nxt_s;
      we_r       <= we_nxt_s;
      addr_r     <= addr_nxt_s;
      dout_r     <= dout_nxt_s;
      if (state_r == ST_CAP && idx_r == '0) begin
        stg_en_r   <= data_in[NUM_LEDS-1:0];
        stg_mode_r <= data_in[4 +: NUM_LEDS];
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (state_r == ST_CAP && idx_r == KW'(i + 1)) begin
          stg_half_r[i] <= data_in;
        end
        shd_half_r[i] <= shd_half_nxt_s[i];
      end
      if (state_r == ST_WR) begin
        scan_cnt_r <= scan_cnt_r + 8'd1;
      end
    end
  end

  // LED outputs and blink counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      led_r <= led_nxt_s;
      for (int i = 0; i < NUM_LEDS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign led      = led_r;
  assign cs       = cs_r;
  assign oe       = oe_r;
  assign we       = we_r;
  assign addr     = addr_r;
  assign data_out = dout_r;

endmodule
